// File: rtl/spi_tft_init_seq.sv
// Table-driven TFT panel init sequencer: walks a command/data table into the SPI byte
// sender via req/ack, with full or window-only runs, per-entry delays and an ack timeout.
module spi_tft_init_seq #(
  parameter logic [15:0] SCREEN_WIDTH  = 16'd320,
  parameter logic [15:0] SCREEN_HEIGHT = 16'd240,
  parameter logic [1:0]  SCREEN_ORIENT = 2'b00,
  parameter logic [31:0] DELAY_LONG    = 32'd255_000,
  parameter logic [31:0] DELAY_SHORT   = 32'd10,
  parameter logic [31:0] ACK_TIMEOUT   = 32'd100_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tft_screen_init_req_i,
  input  logic       tft_screen_init_mode_i,
  output logic       tft_screen_init_ack_o,
  output logic       tft_screen_init_busy_o,
  output logic       tft_screen_init_err_o,
  output logic [7:0] tft_screen_init_data_o,
  output logic       tft_screen_init_dc_o,
  output logic       spi_send_init_req_o,
  output logic       spi_send_init_end_o,
  input  logic       spi_send_init_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_DELAY = 3'd2,
    S_ACK   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [15:0] W_END      = SCREEN_WIDTH - 16'd1;
  localparam logic [15:0] H_END      = SCREEN_HEIGHT - 16'd1;
  localparam logic [4:0]  FULL_START = 5'd0;
  localparam logic [4:0]  FULL_END   = 5'd18;
  localparam logic [4:0]  WIN_START  = 5'd6;
  localparam logic [4:0]  WIN_END    = 5'd15;

  function automatic logic [7:0] madctl(input logic [1:0] orient);
    logic [7:0] m;
    case (orient)
      2'b00:   m = 8'h08;
      2'b01:   m = 8'h68;
      2'b10:   m = 8'hC8;
      2'b11:   m = 8'hA8;
      default: m = 8'h08;
    endcase
    return m;
  endfunction

  // Returns {dc, byte} for a table index.
  function automatic logic [8:0] entry(input logic [4:0] idx);
    logic [8:0] e;
    case (idx)
      5'd0:    e = {1'b0, 8'h01};
      5'd1:    e = {1'b0, 8'h11};
      5'd2:    e = {1'b0, 8'h3A};
      5'd3:    e = {1'b1, 8'h55};
      5'd4:    e = {1'b0, 8'h36};
      5'd5:    e = {1'b1, madctl(SCREEN_ORIENT)};
      5'd6:    e = {1'b0, 8'h2A};
      5'd7:    e = {1'b1, 8'h00};
      5'd8:    e = {1'b1, 8'h00};
      5'd9:    e = {1'b1, W_END[15:8]};
      5'd10:   e = {1'b1, W_END[7:0]};
      5'd11:   e = {1'b0, 8'h2B};
      5'd12:   e = {1'b1, 8'h00};
      5'd13:   e = {1'b1, 8'h00};
      5'd14:   e = {1'b1, H_END[15:8]};
      5'd15:   e = {1'b1, H_END[7:0]};
      5'd16:   e = {1'b0, 8'h21};
      5'd17:   e = {1'b0, 8'h13};
      5'd18:   e = {1'b0, 8'h29};
      default: e = {1'b0, 8'h00};
    endcase
    return e;
  endfunction

  function automatic logic is_long(input logic [4:0] idx);
    return (idx == 5'd0) || (idx == 5'd1) || (idx == 5'd17) || (idx == 5'd18);
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_idx;
  logic        r_mode;
  logic [31:0] r_tcnt;
  logic [31:0] r_dcnt;
  logic [8:0]  w_entry;
  logic [31:0] w_delay_n;
  logic [4:0]  w_start_idx;
  logic [4:0]  w_end_idx;
  logic        w_delay_done;

  // Table lookup and per-run bounds.
  always_comb begin
    w_entry      = entry(r_idx);
    w_delay_n    = is_long(r_idx) ? DELAY_LONG : DELAY_SHORT;
    w_start_idx  = tft_screen_init_mode_i ? WIN_START : FULL_START;
    w_end_idx    = r_mode ? WIN_END : FULL_END;
    w_delay_done = (r_dcnt == (w_delay_n - 32'd1));
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; ack beats a coincident timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (tft_screen_init_req_i) w_next = S_SEND;
        else                       w_next = r_state;
      end
      S_SEND: begin
        if (spi_send_init_ack_i)                   w_next = S_DELAY;
        else if (r_tcnt == (ACK_TIMEOUT - 32'd1))  w_next = S_ERR;
        else                                       w_next = S_SEND;
      end
      S_DELAY: begin
        if (!w_delay_done)            w_next = S_DELAY;
        else if (r_idx == w_end_idx)  w_next = S_ACK;
        else                          w_next = S_SEND;
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Index, mode latch and cycle counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idx  <= 5'd0;
      r_mode <= 1'b0;
      r_tcnt <= 32'd0;
      r_dcnt <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (tft_screen_init_req_i) begin
            r_mode <= tft_screen_init_mode_i;
            r_idx  <= w_start_idx;
            r_tcnt <= 32'd0;
            r_dcnt <= 32'd0;
          end
        end
        S_SEND: begin
          if (spi_send_init_ack_i) begin
            r_tcnt <= 32'd0;
            r_dcnt <= 32'd0;
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        S_DELAY: begin
          if (w_delay_done) begin
            r_dcnt <= 32'd0;
            if (r_idx != w_end_idx) r_idx <= r_idx + 5'd1;
          end else begin
            r_dcnt <= r_dcnt + 32'd1;
          end
        end
        default: begin
          r_tcnt <= 32'd0;
          r_dcnt <= 32'd0;
        end
      endcase
    end
  end

  // Output decode from the state register and current index.
  always_comb begin
    tft_screen_init_data_o = w_entry[7:0];
    tft_screen_init_dc_o   = w_entry[8];
    tft_screen_init_ack_o  = (r_state == S_ACK);
    tft_screen_init_busy_o = (r_state == S_SEND) || (r_state == S_DELAY);
    tft_screen_init_err_o  = (r_state == S_ERR);
    spi_send_init_req_o    = (r_state == S_SEND);
    spi_send_init_end_o    = (r_state == S_DELAY);
  end

endmodule

// File: tb/tb_spi_tft_init_seq.sv
// Directed bench: two instances (default geometry, and 240x320 orient 01) driven by a
// small SPI ack model, checked against hand-computed byte/dc/delay tables.
module tb_spi_tft_init_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_i  [2];
  logic       mode_i [2];
  logic       ack_i  [2];
  logic       ack_o  [2];
  logic       busy_o [2];
  logic       err_o  [2];
  logic [7:0] data_o [2];
  logic       dc_o   [2];
  logic       sreq_o [2];
  logic       send_o [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_b [2][19];
  logic       exp_dc [19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  spi_tft_init_seq #(
    .DELAY_LONG(32'd20), .DELAY_SHORT(32'd3), .ACK_TIMEOUT(32'd50)
  ) u_dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .tft_screen_init_req_i(req_i[0]), .tft_screen_init_mode_i(mode_i[0]),
    .tft_screen_init_ack_o(ack_o[0]), .tft_screen_init_busy_o(busy_o[0]),
    .tft_screen_init_err_o(err_o[0]), .tft_screen_init_data_o(data_o[0]),
    .tft_screen_init_dc_o(dc_o[0]), .spi_send_init_req_o(sreq_o[0]),
    .spi_send_init_end_o(send_o[0]), .spi_send_init_ack_i(ack_i[0])
  );

  spi_tft_init_seq #(
    .SCREEN_WIDTH(16'd240), .SCREEN_HEIGHT(16'd320), .SCREEN_ORIENT(2'b01),
    .DELAY_LONG(32'd20), .DELAY_SHORT(32'd3), .ACK_TIMEOUT(32'd50)
  ) u_dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .tft_screen_init_req_i(req_i[1]), .tft_screen_init_mode_i(mode_i[1]),
    .tft_screen_init_ack_o(ack_o[1]), .tft_screen_init_busy_o(busy_o[1]),
    .tft_screen_init_err_o(err_o[1]), .tft_screen_init_data_o(data_o[1]),
    .tft_screen_init_dc_o(dc_o[1]), .spi_send_init_req_o(sreq_o[1]),
    .spi_send_init_end_o(send_o[1]), .spi_send_init_ack_i(ack_i[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_dl(input int k);
    return (k <= 1 || k >= 17) ? 20 : 3;
  endfunction

  task automatic chk_reset_outs(input int u);
    chk("rst_ack", ack_o[u], 1'b0);
    chk("rst_busy", busy_o[u], 1'b0);
    chk("rst_err", err_o[u], 1'b0);
    chk("rst_req", sreq_o[u], 1'b0);
    chk("rst_end", send_o[u], 1'b0);
    chk("rst_data", data_o[u], 8'h01);
    chk("rst_dc", dc_o[u], 1'b0);
  endtask

  // Called at a negedge; leaves at the negedge where the DUT is in SEND.
  task automatic start(input int u, input logic m);
    req_i[u] = 1'b1;
    mode_i[u] = m;
    @(negedge clk);
    req_i[u] = 1'b0;
  endtask

  task automatic do_byte(input int u, input int k, input int lat, input bit spur,
                         input bit last, input bit rst_mid);
    int n;
    n = 0;
    while (!sreq_o[u] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("req_seen", sreq_o[u], 1'b1);
    chk("data", data_o[u], exp_b[u][k]);
    chk("dc", dc_o[u], exp_dc[k]);
    chk("busy", busy_o[u], 1'b1);
    repeat (lat) @(negedge clk);
    chk("data_stable", data_o[u], exp_b[u][k]);
    ack_i[u] = 1'b1;
    @(negedge clk);
    ack_i[u] = 1'b0;
    if (rst_mid) begin
      chk("end_before_rst", send_o[u], 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_outs(u);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      n = 0;
      while (send_o[u] && n < 100) begin
        if (spur && n == 0) begin
          ack_i[u] = 1'b1;
          req_i[u] = 1'b1;
          mode_i[u] = ~mode_i[u];
        end
        n++;
        @(negedge clk);
        ack_i[u] = 1'b0;
        req_i[u] = 1'b0;
      end
      chk("delay_len", n, exp_dl(k));
      chk("ack_pulse", ack_o[u], last);
      if (last) begin
        @(negedge clk);
        chk("ack_drop", ack_o[u], 1'b0);
        chk("idle_busy", busy_o[u], 1'b0);
      end
    end
  endtask

  task automatic bytes(input int u, input int first, input int last, input int slow,
                       input bit spur, input bit fin);
    for (int k = first; k <= last; k++)
      do_byte(u, k, (k == slow) ? 49 : 2, spur, fin && (k == last), 1'b0);
  endtask

  initial begin
    logic seen_ack;
    int   n;
    exp_b[0] = '{8'h01, 8'h11, 8'h3A, 8'h55, 8'h36, 8'h08, 8'h2A, 8'h00, 8'h00, 8'h01,
                 8'h3F, 8'h2B, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h21, 8'h13, 8'h29};
    exp_b[1] = '{8'h01, 8'h11, 8'h3A, 8'h55, 8'h36, 8'h68, 8'h2A, 8'h00, 8'h00, 8'h00,
                 8'hEF, 8'h2B, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h21, 8'h13, 8'h29};
    for (int u = 0; u < 2; u++) begin
      req_i[u] = 1'b0;
      mode_i[u] = 1'b0;
      ack_i[u] = 1'b0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    chk_reset_outs(0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean full init, default geometry
    start(0, 1'b0);
    bytes(0, 0, 18, -1, 1'b0, 1'b1);

    // Spurious ack in IDLE, then a run with spurious ack/req/mode noise in DELAY
    ack_i[0] = 1'b1;
    @(negedge clk);
    ack_i[0] = 1'b0;
    @(negedge clk);
    chk("idle_spur_busy", busy_o[0], 1'b0);
    chk("idle_spur_req", sreq_o[0], 1'b0);
    chk("idle_spur_data", data_o[0], 8'h29);
    start(0, 1'b0);
    bytes(0, 0, 18, -1, 1'b1, 1'b1);

    // Window-only on the alternate geometry, then full run for MADCTL 68
    start(1, 1'b1);
    bytes(1, 6, 15, -1, 1'b0, 1'b1);
    start(1, 1'b0);
    bytes(1, 0, 18, -1, 1'b0, 1'b1);

    // Ack withheld on byte 4 -> timeout
    start(0, 1'b0);
    bytes(0, 0, 3, -1, 1'b0, 1'b0);
    n = 0;
    while (!sreq_o[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("to_data", data_o[0], 8'h36);
    n = 0;
    seen_ack = 1'b0;
    while (sreq_o[0] && n < 200) begin
      seen_ack = seen_ack | ack_o[0];
      n++;
      @(negedge clk);
    end
    chk("to_send_cycles", n, 50);
    chk("to_err", err_o[0], 1'b1);
    chk("to_req", sreq_o[0], 1'b0);
    chk("to_end", send_o[0], 1'b0);
    chk("to_busy", busy_o[0], 1'b0);
    chk("to_no_ack", seen_ack | ack_o[0], 1'b0);
    repeat (5) @(negedge clk);
    chk("to_err_sticky", err_o[0], 1'b1);
    start(0, 1'b0);
    chk("restart_err_clr", err_o[0], 1'b0);
    chk("restart_data", data_o[0], 8'h01);
    bytes(0, 0, 18, -1, 1'b0, 1'b1);

    // Ack coincident with the last allowed SEND cycle on byte 7
    start(0, 1'b0);
    bytes(0, 0, 18, 7, 1'b0, 1'b1);
    chk("coinc_no_err", err_o[0], 1'b0);

    // Reset during DELAY after byte 11, then a fresh run
    start(0, 1'b0);
    bytes(0, 0, 10, -1, 1'b0, 1'b0);
    do_byte(0, 11, 2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_reset_outs(0);
    start(0, 1'b0);
    chk("post_rst_data", data_o[0], 8'h01);
    bytes(0, 0, 18, -1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
